hack_ctrl_fsm: RTL and testbench

//  Multi-cycle Hack control unit; the consumer-side partner of the ALU. Fetches
//  one instruction from ROM per handshake and drives the ALU control bits
//  (zx,nx,zy,ny,f,no) and y-operand select. Samples the ALU zr/ng flags to

---
 rtl/hack_pkg.sv | 37 +++
 rtl/hack_ctrl_fsm_if.sv | 45 ++++
 rtl/hack_jump_unit.sv | 17 +
 rtl/hack_ctrl_fsm.sv | 131 +++++++++++++
 tb/tb_hack_ctrl_fsm.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack control unit: FSM state encoding, instruction
// field positions and the helpers used to pick an instruction word apart.
package hack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEMRD  = 3'd3,
      ST_EXEC   = 3'd4
   } state_t;

   localparam int IR_W       = 16;
   localparam int IR_CBIT    = 15;
   localparam int IR_ABIT    = 12;
   localparam int IR_COMP_HI = 11;
   localparam int IR_COMP_LO = 6;
   localparam int IR_DEST_A  = 5;
   localparam int IR_DEST_D  = 4;
   localparam int IR_DEST_M  = 3;
   localparam int IR_JUMP_HI = 2;
   localparam int IR_JUMP_LO = 0;

   // Bit positions inside the 3-bit jump field.
   localparam int JMP_LT = 2;
   localparam int JMP_EQ = 1;
   localparam int JMP_GT = 0;

   function automatic logic is_c_instr(input logic [IR_W-1:0] instr);
      return instr[IR_CBIT];
   endfunction

   function automatic logic uses_m(input logic [IR_W-1:0] instr);
      return instr[IR_CBIT] & instr[IR_ABIT];
   endfunction

endpackage

// File: rtl/hack_ctrl_fsm_if.sv
// Bus bundle between the Hack control unit and its ROM, ALU and register datapath.
// master = control unit, slave = datapath/memory side.
interface hack_ctrl_fsm_if;

   logic        rom_req;
   logic        rom_valid;
   logic [15:0] rom_data;

   logic        alu_zx;
   logic        alu_nx;
   logic        alu_zy;
   logic        alu_ny;
   logic        alu_f;
   logic        alu_no;
   logic        alu_sel_am;
   logic        alu_zr;
   logic        alu_ng;

   logic        a_load;
   logic        a_sel_instr;
   logic        d_load;
   logic        m_write;
   logic        ram_rd;
   logic        pc_load;
   logic        pc_inc;

   modport master (
      output rom_req,
      input  rom_valid,
      input  rom_data,
      output alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_sel_am,
      input  alu_zr, alu_ng,
      output a_load, a_sel_instr, d_load, m_write, ram_rd, pc_load, pc_inc
   );

   modport slave (
      input  rom_req,
      output rom_valid,
      output rom_data,
      input  alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_sel_am,
      output alu_zr, alu_ng,
      input  a_load, a_sel_instr, d_load, m_write, ram_rd, pc_load, pc_inc
   );

endinterface

// File: rtl/hack_jump_unit.sv
// Combinational jump resolver: decides from the jump field and the ALU flags
// whether the PC should be loaded from A.
module hack_jump_unit
   import hack_pkg::*;
(
   input  logic [2:0] jump,
   input  logic       zr,
   input  logic       ng,
   output logic       taken
);

   // A strictly positive result is the only case with both flags clear.
   assign taken = (jump[JMP_LT] & ng)
                | (jump[JMP_EQ] & zr)
                | (jump[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_ctrl_fsm.sv
// Multi-cycle Hack control unit: fetches one instruction per ROM handshake,
// drives the ALU control bits and issues A/D/M/PC register controls.
module hack_ctrl_fsm
   import hack_pkg::*;
#(
   parameter int RAM_LAT = 1
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   output logic           busy,
   hack_ctrl_fsm_if.master bus
);

   localparam int CNT_W = $clog2(RAM_LAT + 1);

   state_t            state;
   state_t            next_state;
   logic [IR_W-1:0]   ir;
   logic [CNT_W-1:0]  wait_cnt;
   logic              jump_taken;
   logic              unused_ir_bits;

   // The two bits between the C marker and the a-bit carry no meaning.
   assign unused_ir_bits = ^ir[IR_CBIT-1:IR_ABIT+1];

   hack_jump_unit u_jump (
      .jump  (ir[IR_JUMP_HI:IR_JUMP_LO]),
      .zr    (bus.alu_zr),
      .ng    (bus.alu_ng),
      .taken (jump_taken)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The instruction register only listens to the ROM while a fetch is pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir       <= '0;
         wait_cnt <= '0;
      end else begin
         if (state == ST_FETCH && bus.rom_valid) begin
            ir <= bus.rom_data;
         end
         if (state == ST_DECODE) begin
            wait_cnt <= CNT_W'(RAM_LAT - 1);
         end else if (state == ST_MEMRD && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (run) next_state = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.rom_valid) next_state = ST_DECODE;
         end
         ST_DECODE: begin
            if (!is_c_instr(ir)) begin
               next_state = run ? ST_FETCH : ST_IDLE;
            end else if (uses_m(ir)) begin
               next_state = ST_MEMRD;
            end else begin
               next_state = ST_EXEC;
            end
         end
         // Counter was preloaded with RAM_LAT-1, so reaching zero ends the wait.
         ST_MEMRD: begin
            if (wait_cnt == '0) next_state = ST_EXEC;
         end
         ST_EXEC: begin
            next_state = run ? ST_FETCH : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy            = (state != ST_IDLE);
      bus.rom_req     = 1'b0;
      bus.alu_sel_am  = 1'b0;
      bus.a_load      = 1'b0;
      bus.a_sel_instr = 1'b0;
      bus.d_load      = 1'b0;
      bus.m_write     = 1'b0;
      bus.ram_rd      = 1'b0;
      bus.pc_load     = 1'b0;
      bus.pc_inc      = 1'b0;
      {bus.alu_zx, bus.alu_nx, bus.alu_zy,
       bus.alu_ny, bus.alu_f,  bus.alu_no} = ir[IR_COMP_HI:IR_COMP_LO];

      case (state)
         ST_FETCH: begin
            bus.rom_req = 1'b1;
         end
         ST_DECODE: begin
            if (!is_c_instr(ir)) begin
               bus.a_load      = 1'b1;
               bus.a_sel_instr = 1'b1;
               bus.pc_inc      = 1'b1;
            end
         end
         ST_MEMRD: begin
            bus.ram_rd     = 1'b1;
            bus.alu_sel_am = ir[IR_ABIT];
         end
         ST_EXEC: begin
            bus.alu_sel_am = ir[IR_ABIT];
            bus.a_load     = ir[IR_DEST_A];
            bus.d_load     = ir[IR_DEST_D];
            bus.m_write    = ir[IR_DEST_M];
            bus.pc_load    = jump_taken;
            bus.pc_inc     = ~jump_taken;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_hack_ctrl_fsm.sv
// Self-checking bench for hack_ctrl_fsm: a ROM-side driver pushes the expected
// commit controls per instruction; a monitor pops them when the DUT commits.
module tb_hack_ctrl_fsm;

   localparam int RAM_LAT = 2;

   typedef struct {
      logic [12:0] ctrl;
      int          ram_cycles;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic busy;

   int   vec_count   = 0;
   int   miss_count  = 0;
   int   ram_rd_seen = 0;
   exp_t sb_q[$];

   hack_ctrl_fsm_if bus ();

   hack_ctrl_fsm #(.RAM_LAT(RAM_LAT)) dut (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .busy (busy),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs_comp();
      return {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
   endfunction

   function automatic logic [12:0] obs_ctrl();
      return {bus.a_load, bus.a_sel_instr, bus.d_load, bus.m_write,
              bus.pc_load, bus.pc_inc, bus.alu_sel_am, obs_comp()};
   endfunction

   // Reference behaviour of the commit cycle of one instruction.
   function automatic logic [12:0] model_ctrl(input logic [15:0] instr, input logic zr,
                                              input logic ng);
      logic [5:0] comp;
      logic       jmp;
      comp = instr[11:6];
      if (!instr[15]) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, comp};
      jmp = 1'b0;
      if (instr[2] && ng) jmp = 1'b1;
      if (instr[1] && zr) jmp = 1'b1;
      if (instr[0] && !ng && !zr) jmp = 1'b1;
      return {instr[5], 1'b0, instr[4], instr[3], jmp, !jmp, instr[12], comp};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; serves one ROM request after wait_cycles extra cycles.
   task automatic applyStimulus(input logic [15:0] instr, input logic zr, input logic ng,
                                input int wait_cycles);
      int   n;
      exp_t e;
      n = 0;
      while (!bus.rom_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rom_req) begin
         checkOutput("rom_req_wait", 32'd0, 32'd1);
         return;
      end
      repeat (wait_cycles) @(negedge clk);
      e.ctrl       = model_ctrl(instr, zr, ng);
      e.ram_cycles = (instr[15] && instr[12]) ? RAM_LAT : 0;
      sb_q.push_back(e);
      bus.alu_zr    = zr;
      bus.alu_ng    = ng;
      bus.rom_data  = instr;
      bus.rom_valid = 1'b1;
      @(negedge clk);
      bus.rom_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("sb_drain", sb_q.size(), 0);
   endtask

   // Every instruction commits exactly once, with pc_inc or pc_load.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         ram_rd_seen = 0;
      end else begin
         if (bus.ram_rd) ram_rd_seen++;
         if (bus.pc_inc || bus.pc_load) begin
            checkOutput("pc_exclusive", {31'd0, bus.pc_inc & bus.pc_load}, 32'd0);
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_commit", obs_ctrl(), 32'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("commit_ctrl", obs_ctrl(), e.ctrl);
               checkOutput("ram_rd_cycles", ram_rd_seen, e.ram_cycles);
            end
            ram_rd_seen = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0] flags;
      int         n;
      bus.rom_valid = 1'b0;
      bus.rom_data  = '0;
      bus.alu_zr    = 1'b0;
      bus.alu_ng    = 1'b0;

      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_outputs", {bus.rom_req, bus.ram_rd, obs_ctrl()}, 0);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;

      // Reset while executing D=D+1 must clear everything in the same cycle.
      applyStimulus(16'hE7D0, 1'b0, 1'b0, 1);
      n = 0;
      while (!bus.d_load && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("exec_reached", bus.d_load, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_outputs", {bus.rom_req, bus.ram_rd, obs_ctrl()}, 0);
      @(negedge clk);
      rst = 1'b0;

      // A-instruction followed immediately by a new request.
      applyStimulus(16'h0015, 1'b0, 1'b0, 1);
      @(negedge clk);
      checkOutput("rom_req_refetch", bus.rom_req, 1);

      applyStimulus(16'hE7D0, 1'b0, 1'b0, 0);
      applyStimulus(16'hEA82, 1'b1, 1'b0, 0);
      applyStimulus(16'hEA82, 1'b0, 1'b1, 2);
      applyStimulus(16'hFDC8, 1'b0, 1'b0, 1);

      for (int i = 0; i < 24; i++) begin
         flags = 2'($urandom_range(0, 2));
         applyStimulus(16'($urandom), flags[0], flags[1], $urandom_range(0, 2));
      end

      // Dropping run mid-read lets the instruction finish, then the unit idles.
      applyStimulus(16'hFDC8, 1'b0, 1'b0, 0);
      @(negedge clk);
      checkOutput("memrd_ram_rd", bus.ram_rd, 1);
      run = 1'b0;
      waitDrain();
      repeat (2) @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_rom_req", bus.rom_req, 0);
      bus.rom_data  = 16'hFFFF;
      bus.rom_valid = 1'b1;
      @(negedge clk);
      bus.rom_valid = 1'b0;
      @(negedge clk);
      checkOutput("idle_ir_kept", obs_comp(), 6'b110111);
      checkOutput("idle_no_writes",
                  {bus.a_load, bus.d_load, bus.m_write, bus.pc_load, bus.pc_inc, bus.ram_rd}, 0);
      checkOutput("idle_busy_after_valid", busy, 0);
      checkOutput("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
